// File: rtl/dds_pkg.sv
// Shared types and elaboration helpers for the DDS waveform generator.
package dds_pkg;

  typedef enum logic [1:0] {
    DDS_SINE   = 2'd0,
    DDS_SQUARE = 2'd1,
    DDS_SAW    = 2'd2,
    DDS_TRI    = 2'd3
  } dds_mode_t;

  // Number of entries in a quarter-wave table addressed by rom_aw bits.
  function automatic int rom_entries(input int rom_aw);
    return 1 << rom_aw;
  endfunction

  // Full-scale positive magnitude representable in mag_w unsigned bits.
  function automatic int wave_amp(input int mag_w);
    return (1 << mag_w) - 1;
  endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine magnitude table with a registered read port.
// Entries are sampled at the bin centre, so the table never holds an
// exact zero and mirrored quadrants join without a duplicated sample.
module dds_sine_rom
  import dds_pkg::*;
#(
  parameter int ROM_AW = 6,
  parameter int MAG_W  = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ROM_AW-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  localparam int  ENTRIES = rom_entries(ROM_AW);
  localparam real AMP     = real'(wave_amp(MAG_W));
  localparam real PI      = 3.14159265358979323846;

  function automatic logic [MAG_W-1:0] sine_entry(input int k);
    real x;
    x = AMP * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(ENTRIES));
    return MAG_W'($rtoi(x + 0.5));
  endfunction

  logic [MAG_W-1:0] table_q [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_rom
    assign table_q[i] = sine_entry(i);
  end

  // Registered table lookup; cleared on reset so stale magnitudes never leak out.
  always_ff @(posedge clock) begin
    if (!reset_n) mag <= '0;
    else          mag <= table_q[addr];
  end

endmodule

// File: rtl/dds_wavegen.sv
// Direct digital synthesis generator: phase accumulator with tuning word and
// phase offset, configuration handshake with optional update at phase wrap,
// and a 3-stage pipeline producing sine/square/sawtooth/triangle samples.
module dds_wavegen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 12
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_sync,
  input  logic [PHASE_W-1:0]      cfg_ftw,
  input  logic [PHASE_W-1:0]      cfg_poff,
  input  logic [1:0]              cfg_mode,
  output logic signed [OUT_W-1:0] wave_out,
  output logic                    wave_valid,
  output logic                    wrap
);

  localparam logic signed [OUT_W-1:0] AMP = OUT_W'(wave_amp(OUT_W - 1));

  // Arithmetic waveforms from the top OUT_W+1 phase bits.
  function automatic logic signed [OUT_W-1:0] arith_sample(input logic [OUT_W:0] ph,
                                                           input dds_mode_t m);
    logic [OUT_W-1:0] u;
    logic [OUT_W-1:0] v;
    logic signed [OUT_W-1:0] r;
    u = ph[OUT_W-1:0];
    v = ph[OUT_W] ? ~u : u;
    case (m)
      DDS_SQUARE: r = ph[OUT_W] ? -AMP : AMP;
      DDS_SAW:    r = signed'({~ph[OUT_W], ph[OUT_W-1:1]});
      DDS_TRI:    r = signed'({~v[OUT_W-1], v[OUT_W-2:0]});
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Turn an unsigned table magnitude into a signed sample for the lower half-cycle.
  function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-2:0] mag,
                                                         input logic neg);
    logic signed [OUT_W-1:0] s;
    s = signed'({1'b0, mag});
    return neg ? -s : s;
  endfunction

  logic [PHASE_W-1:0] ftw_sh, poff_sh, ftw_act, poff_act;
  dds_mode_t          mode_sh, mode_act;
  logic               pending, sync_pend;

  logic [PHASE_W-1:0] acc, acc_next;
  logic               carry;
  logic               step_wrap;

  assign {carry, acc_next} = {1'b0, acc} + {1'b0, ftw_act};
  assign step_wrap         = enable & carry;

  // Configuration handshake: capture into shadow, then commit atomically to active.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cfg_ready <= 1'b0;
      pending   <= 1'b0;
      sync_pend <= 1'b0;
      ftw_sh    <= '0;
      poff_sh   <= '0;
      mode_sh   <= DDS_SINE;
      ftw_act   <= '0;
      poff_act  <= '0;
      mode_act  <= DDS_SINE;
    end else if (cfg_valid && cfg_ready) begin
      ftw_sh    <= cfg_ftw;
      poff_sh   <= cfg_poff;
      mode_sh   <= dds_mode_t'(cfg_mode);
      sync_pend <= cfg_sync;
      pending   <= 1'b1;
      cfg_ready <= 1'b0;
    end else if (pending && (!sync_pend || step_wrap)) begin
      ftw_act   <= ftw_sh;
      poff_act  <= poff_sh;
      mode_act  <= mode_sh;
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (!pending) begin
      cfg_ready <= 1'b1;
    end
  end

  // Phase accumulator; wrap flags the carry-out of an enabled step.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc  <= '0;
      wrap <= 1'b0;
    end else begin
      if (enable) acc <= acc_next;
      wrap <= step_wrap;
    end
  end

  // ---- stage 1: phase = acc + offset, configuration snapshot ----
  logic [PHASE_W-1:0] p_p1;
  dds_mode_t          mode_p1;
  logic               vld_p1;

  // Register the offset phase together with the mode it must be rendered in.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      p_p1    <= '0;
      mode_p1 <= DDS_SINE;
      vld_p1  <= 1'b0;
    end else begin
      p_p1    <= acc + poff_act;
      mode_p1 <= mode_act;
      vld_p1  <= enable;
    end
  end

  logic [ADDR_W-1:0] a_p1;
  logic [ADDR_W-3:0] k_p1, rom_addr;
  logic              unused_phase;

  assign a_p1         = p_p1[PHASE_W-1 -: ADDR_W];
  assign k_p1         = a_p1[ADDR_W-3:0];
  assign rom_addr     = a_p1[ADDR_W-2] ? ~k_p1 : k_p1;
  assign unused_phase = ^p_p1;

  // ---- stage 2: table lookup and arithmetic waveforms ----
  logic [OUT_W-2:0]        mag_p2;
  logic                    neg_p2;
  dds_mode_t               mode_p2;
  logic signed [OUT_W-1:0] arith_p2;
  logic                    vld_p2;

  dds_sine_rom #(
    .ROM_AW (ADDR_W - 2),
    .MAG_W  (OUT_W - 1)
  ) u_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .addr    (rom_addr),
    .mag     (mag_p2)
  );

  // Carry the sine sign and the arithmetic sample alongside the table read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      neg_p2   <= 1'b0;
      mode_p2  <= DDS_SINE;
      arith_p2 <= '0;
      vld_p2   <= 1'b0;
    end else begin
      neg_p2   <= a_p1[ADDR_W-1];
      mode_p2  <= mode_p1;
      arith_p2 <= arith_sample(p_p1[PHASE_W-1 -: OUT_W+1], mode_p1);
      vld_p2   <= vld_p1;
    end
  end

  // ---- stage 3: sign application and output select ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wave_out   <= '0;
      wave_valid <= 1'b0;
    end else begin
      wave_out   <= (mode_p2 == DDS_SINE) ? apply_sign(mag_p2, neg_p2) : arith_p2;
      wave_valid <= vld_p2;
    end
  end

endmodule

// File: tb/tb_dds_wavegen.sv
// Directed self-checking bench for dds_wavegen (PHASE_W=32, ADDR_W=8, OUT_W=12).
module tb_dds_wavegen;
  import dds_pkg::*;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                cfg_valid;
  logic                cfg_ready;
  logic                cfg_sync;
  logic [31:0]         cfg_ftw;
  logic [31:0]         cfg_poff;
  logic [1:0]          cfg_mode;
  logic signed [11:0]  wave_out;
  logic                wave_valid;
  logic                wrap;

  int tests = 0;
  int fails = 0;
  int first_wrap;
  int wrap_cnt;
  int sine_exp [4] = '{25, 2047, -25, -2047};

  always #5 clock = ~clock;

  dds_wavegen #(
    .PHASE_W (32),
    .ADDR_W  (8),
    .OUT_W   (12)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_sync   (cfg_sync),
    .cfg_ftw    (cfg_ftw),
    .cfg_poff   (cfg_poff),
    .cfg_mode   (cfg_mode),
    .wave_out   (wave_out),
    .wave_valid (wave_valid),
    .wrap       (wrap)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Count wrap pulses over n cycles, remembering the cycle index of the first.
  task automatic count_wraps(input int n, output int first, output int cnt);
    first = 0;
    cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (wrap) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  // Reset, load a configuration immediately, enable; returns just after edge E3.
  task automatic start(input logic [31:0] ftw, input logic [31:0] poff, input logic [1:0] mode);
    enable    = 1'b0;
    cfg_valid = 1'b0;
    reset_n   = 1'b0;
    step(2);
    reset_n   = 1'b1;
    step(1);
    cfg_ftw   = ftw;
    cfg_poff  = poff;
    cfg_mode  = mode;
    cfg_sync  = 1'b0;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    step(1);
    enable    = 1'b1;
    step(3);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_sync  = 1'b0;
    cfg_ftw   = '0;
    cfg_poff  = '0;
    cfg_mode  = DDS_SINE;
    step(3);
    check("reset_wave_out", wave_out, 0);
    check("reset_wave_valid", wave_valid, 0);
    check("reset_wrap", wrap, 0);
    check("reset_cfg_ready", cfg_ready, 0);
    reset_n = 1'b1;
    step(1);
    check("ready_after_release", cfg_ready, 1);

    // Sine, ftw quarter cycle, immediate update
    cfg_ftw   = 32'h4000_0000;
    cfg_valid = 1'b1;
    step(1);
    check("ready_drop_on_accept", cfg_ready, 0);
    cfg_valid = 1'b0;
    step(1);
    check("ready_back_after_apply", cfg_ready, 1);
    enable = 1'b1;
    step(2);
    check("valid_low_at_e2", wave_valid, 0);
    step(1);
    check("valid_high_at_e3", wave_valid, 1);
    for (int n = 3; n <= 10; n++) begin
      if (n > 3) step(1);
      check($sformatf("sine_e%0d", n), wave_out, sine_exp[(n - 3) % 4]);
      check($sformatf("sine_wrap_e%0d", n), wrap, (n % 4 == 0));
    end
    enable = 1'b0;
    step(1);
    check("hold_wrap_low", wrap, 0);
    step(3);
    check("hold_wave_repeat", wave_out, -25);
    check("hold_valid_low", wave_valid, 0);

    // Sine with half-cycle phase offset
    start(32'h4000_0000, 32'h8000_0000, DDS_SINE);
    check("poff_e3", wave_out, -25);
    step(1); check("poff_e4", wave_out, -2047);
    step(1); check("poff_e5", wave_out, 25);
    step(1); check("poff_e6", wave_out, 2047);

    // Reset while a wrap-synchronised config is pending
    cfg_ftw   = 32'h1000_0000;
    cfg_poff  = 32'h0;
    cfg_mode  = DDS_SQUARE;
    cfg_sync  = 1'b1;
    cfg_valid = 1'b1;
    step(1);
    check("pend_accept_ready_low", cfg_ready, 0);
    cfg_valid = 1'b0;
    reset_n   = 1'b0;
    step(1);
    check("midreset_wave_out", wave_out, 0);
    check("midreset_valid", wave_valid, 0);
    check("midreset_wrap", wrap, 0);
    check("midreset_ready", cfg_ready, 0);
    reset_n = 1'b1;
    count_wraps(40, first_wrap, wrap_cnt);
    check("discarded_cfg_no_wraps", wrap_cnt, 0);
    check("discarded_cfg_wave", wave_out, 25);
    check("discarded_cfg_ready", cfg_ready, 1);

    // Square, eighth-cycle tuning word
    start(32'h2000_0000, 32'h0, DDS_SQUARE);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) step(1);
      check($sformatf("square_%0d", n), wave_out, (n < 4) ? 2047 : -2047);
    end

    // Triangle corner points
    start(32'h4000_0000, 32'h0, DDS_TRI);
    check("tri_0", wave_out, -2048);
    step(1); check("tri_1", wave_out, 0);
    step(1); check("tri_2", wave_out, 2047);
    step(1); check("tri_3", wave_out, -1);

    // Sawtooth ramp and wrap period
    start(32'h0100_0000, 32'h0, DDS_SAW);
    for (int n = 0; n < 3; n++) begin
      if (n > 0) step(1);
      check($sformatf("saw_%0d", n), wave_out, -2048 + 16 * n);
    end
    count_wraps(295, first_wrap, wrap_cnt);
    check("saw_first_wrap_e256", first_wrap + 5, 256);
    check("saw_wrap_count", wrap_cnt, 1);

    // Wrap-synchronised tuning word change
    start(32'h1000_0000, 32'h0, DDS_SAW);
    step(17);
    cfg_ftw   = 32'h0800_0000;
    cfg_poff  = 32'h0;
    cfg_mode  = DDS_SAW;
    cfg_sync  = 1'b1;
    cfg_valid = 1'b1;
    step(1);
    check("sync_accept_ready_low", cfg_ready, 0);
    cfg_valid = 1'b0;
    step(10);
    check("sync_ready_low_e31", cfg_ready, 0);
    check("sync_no_wrap_e31", wrap, 0);
    step(1);
    check("sync_wrap_e32", wrap, 1);
    check("sync_ready_back_e32", cfg_ready, 1);
    count_wraps(38, first_wrap, wrap_cnt);
    check("sync_next_wrap_e64", first_wrap + 32, 64);
    check("sync_wrap_count", wrap_cnt, 1);

    // cfg_valid held across a pending config: one acceptance at a time
    start(32'h1000_0000, 32'h0, DDS_SQUARE);
    cfg_ftw   = 32'h0800_0000;
    cfg_mode  = DDS_SAW;
    cfg_sync  = 1'b1;
    cfg_valid = 1'b1;
    step(1);
    check("hold_first_accept", cfg_ready, 0);
    cfg_ftw  = 32'h0400_0000;
    cfg_mode = DDS_TRI;
    step(11);
    check("hold_ready_low_e15", cfg_ready, 0);
    step(1);
    check("hold_wrap_e16", wrap, 1);
    check("hold_ready_e16", cfg_ready, 1);
    step(1);
    check("hold_second_accept_e17", cfg_ready, 0);
    cfg_valid = 1'b0;
    step(2);
    check("hold_first_cfg_e19", wave_out, -2048);
    step(1);
    check("hold_first_cfg_e20", wave_out, -1920);
    step(27);
    check("hold_second_pending_e47", cfg_ready, 0);
    step(1);
    check("hold_second_wrap_e48", wrap, 1);
    check("hold_second_ready_e48", cfg_ready, 1);
    step(4);
    check("hold_second_cfg_e52", wave_out, -1920);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_wavegen.md
# dds_wavegen

Parametrised direct digital synthesis generator: a PHASE_W-bit phase accumulator with programmable tuning word and phase offset drives a quarter-wave sine ROM or arithmetic waveform logic. It produces a signed OUT_W-bit sample every enabled clock. It replaces the fixed 64-entry, 1-bit table walker in the DDS signal path and feeds the DAC/serialiser stage. Configuration arrives through a valid/ready handshake, with optional glitch-free update at phase wrap.

## Interface
- PHASE_W, 32, accumulator, tuning-word and phase-offset width (≥ ADDR_W+2, ≥ OUT_W+1)
- ADDR_W, 8, full-cycle table address bits; ROM holds 2^(ADDR_W-2) entries
- OUT_W, 12, signed sample width
- clock  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  advance accumulator when 1
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_sync  in  1  0: apply immediately; 1: apply at next phase wrap
- cfg_ftw  in  PHASE_W  frequency tuning word
- cfg_poff  in  PHASE_W  phase offset
- cfg_mode  in  2  0 sine, 1 square, 2 sawtooth, 3 triangle
- wave_out  out  OUT_W  signed sample
- wave_valid  out  1  wave_out corresponds to an enabled phase step
- wrap  out  1  one-cycle pulse on accumulator carry-out

## Operation
- Reset: acc, active ftw/poff/mode, shadow regs, pending, wave_out, wave_valid, wrap, cfg_ready all 0. cfg_ready rises on the first edge after release.
- Handshake: accept on an edge where cfg_valid && cfg_ready; load shadow regs; set pending; cfg_ready drops on the same edge.
- Immediate (cfg_sync=0): active <= shadow on the next edge; pending and cfg_ready restored on that edge.
- Sync (cfg_sync=1): active <= shadow on the edge where the accumulator carries out (enabled step). A wrap on the acceptance edge itself does not count. cfg_ready stays low until applied.
- Accumulator: enable=1 → acc <= acc + ftw_active (mod 2^PHASE_W). wrap=1 when the addition carries. enable=0 → acc holds, wrap=0.
- Phase p = acc + poff_active (mod 2^PHASE_W), a = p[PHASE_W-1 -: ADDR_W], quadrant q = a[ADDR_W-1:ADDR_W-2], k = a[ADDR_W-3:0].
- Sine: rom[k] for q=0; rom[~k] for q=1; −rom[k] for q=2; −rom[~k] for q=3. rom[k] = round((2^(OUT_W-1)−1)·sin(π/2·(k+0.5)/2^(ADDR_W-2))).
- Square: p MSB 0 → +(2^(OUT_W-1)−1), else −(2^(OUT_W-1)−1).
- Sawtooth: p[PHASE_W-1 -: OUT_W] with MSB inverted (phase 0 → −2^(OUT_W-1)).
- Triangle: u = p[PHASE_W-2 -: OUT_W]; v = p MSB ? ~u : u; output v with MSB inverted.
- Mode is applied with ftw/poff atomically; no mixed-configuration sample is ever output.

## Timing
- Pipeline: acc register → stage1 phase add/decode → stage2 ROM/arith register → stage3 sign/mirror → wave_out. Latency from acc value to wave_out is 3 cycles.
- wave_valid = enable delayed 3 cycles. The pipeline always advances; with enable=0, wave_out repeats the held-phase sample.
- Mode/poff changes show on wave_out 3 cycles after the active-register update. ftw takes effect on the first acc step after the update.
- Reset asserted mid-operation: everything returns to reset values on that edge, pending config is discarded, and the pipeline contents are dropped.
- cfg_valid held while cfg_ready=0: nothing accepted, no state change.

## Structure
- Package dds_pkg: mode constants DDS_SINE/SQUARE/SAW/TRI (2-bit typedef dds_mode_t), ROM entry-count/amplitude localparam helpers.
- Sub-module dds_sine_rom: registered read, parameters ADDR_W-2 / OUT_W-1 (unsigned magnitude). Contents computed at elaboration from the formula above.
- Top holds the handshake, shadow/active regs, accumulator and pipeline.

## Test plan
- PHASE_W=32, ADDR_W=8, OUT_W=12, sine, ftw 0x40000000 immediate, enable → wave_out repeats 25, 2047, −25, −2047; wrap every 4th cycle; first valid 3 cycles after enable.
- Square, ftw 0x20000000 → 4 samples +2047, then 4 samples −2047, repeating.
- Sawtooth, ftw 0x01000000, from reset → −2048, −2032, −2016 … (+16 per cycle), wrap every 256 cycles.
- Running ftw 0x10000000; mid-period, accept cfg_sync=1, ftw 0x08000000 → cfg_ready low until the next wrap, then wrap spacing changes from 16 to 32 cycles.
- Sine, ftw 0x40000000, poff 0x80000000 → −25, −2047, 25, 2047. Assert reset while a sync config is pending → outputs 0; after release, the old config is not applied.
- Hold cfg_valid with new values while pending → exactly one acceptance; the second is accepted only after cfg_ready returns.
